scroll_window_buffer: RTL and testbench
=======================================

# scroll_window_buffer

- Parametrised successor to the single-character scrolling buffer.
- Stores up to DEPTH characters of CHAR_W bits written in append order.
- Presents a registered window of WINDOW consecutive characters, starting at a scroll position that advances on each step pulse, for a multi-digit display.
- Supports looping and one-shot scroll modes with completion signalling, and sits between the character-producing controller and the display driver.

## Interface
- CHAR_W, 5, character code width
- DEPTH, 16, maximum stored characters (≥2, not necessarily a power of two)
- WINDOW, 6, characters presented in parallel (1..DEPTH)
- BLANK, 5'd31, code output for empty/padded positions (CHAR_W bits)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear of contents and scroll state
- wr_en  in  1  append wr_data
- wr_data  in  CHAR_W  character to append
- step  in  1  advance scroll position by one
- restart  in  1  return scroll position to 0, re-arm one-shot
- mode  in  1  0 = loop, 1 = one-shot
- win_data  out  WINDOW*CHAR_W  window; char 0 in LSBs
- win_valid  out  1  count ≠ 0
- count  out  $clog2(DEPTH+1)  stored characters N
- wr_full  out  1  N == DEPTH
- wr_drop  out  1  one-cycle pulse: write rejected (full)
- done  out  1  one-cycle pulse: one-shot reached end
- stopped  out  1  one-shot halted

## Operation
- Memory: writes go to address N, then N increments. The array is not reset; every read is gated by N.
- Sequence length: L = N without padding, L = N+WINDOW with padding (see Configuration).
- Scroll position pos: width $clog2(DEPTH+WINDOW+1).
- Virtual index of window char i: v = pos+i.
- Loop mode:
  - v is reduced modulo L; v < N gives mem[v], otherwise BLANK.
  - If N < WINDOW without padding, the message repeats across the window.
- One-shot mode:
  - No modulo; v ≥ L gives BLANK.
  - End position E = L−WINDOW if L > WINDOW, else 0.
- Step, loop mode: pos ← (pos+1 ≥ L) ? 0 : pos+1.
- Step, one-shot mode:
  - If pos < E: pos+1.
  - If pos ≥ E: pos held, done pulses, stopped ← 1.
  - Steps while stopped are ignored (no further done).
- States: EMPTY (N=0), SCROLL, STOPPED.
  - EMPTY→SCROLL on the first accepted write.
  - SCROLL→STOPPED via the one-shot end.
  - STOPPED→SCROLL on restart or a mode change to loop.
  - Any state→EMPTY on clr.
- N = 0: all window chars BLANK, win_valid = 0, steps ignored.
- Write when full: dropped, wr_drop = 1 for one cycle, N unchanged.
- Priority: reset > clr > restart > step. clr also cancels a same-cycle write.
- Write with step in the same cycle: both take effect; the step uses the pre-write L.
- A mode change takes effect at the next step. Switching to one-shot with pos ≥ E stops on that step.

## Timing
- Reset values:
  - win_data = {WINDOW{BLANK}}
  - win_valid, count, wr_full, wr_drop, done, stopped = 0
  - pos = 0
- Reset is asynchronous assert; deassert is taken synchronously by the clk edge. Reset mid-scroll discards contents.
- All outputs are registered. win_data, win_valid, count and wr_full reflect the state updated at edge k from edge k+1 (one-cycle latency from the input sample to the visible window).
- wr_drop and done are asserted the edge after the causing input, for exactly one cycle.
- The sustained rate is one write and one step per cycle.

## Configuration
- SCROLL_BLANK_PAD_EN defined:
  - L = N+WINDOW, so WINDOW BLANK positions follow the message.
  - The message scrolls fully off before looping.
  - One-shot ends with an all-BLANK window.
- Undefined:
  - L = N, and the message wraps directly.
  - One-shot ends with the last WINDOW characters shown.
  - The pad logic is absent.

## Test plan
- Defaults, no pad, loop: write 1,2,3 → win_data chars {1,2,3,1,2,3}, count=3. Step → {2,3,1,2,3,1}. Three steps total → {1,2,3,1,2,3}.
- Write 0..15, then write 7 → wr_full=1, count=16, wr_drop pulses once, mem unchanged. Window {0,1,2,3,4,5}.
- No pad, one-shot, N=8 (0..7), then:
  - two steps → {2..7}, stopped=0
  - third step → done pulses, stopped=1, window unchanged
  - fourth step → no done
  - restart → {0..5}, stopped=0
- SCROLL_BLANK_PAD_EN, loop, N=3 (1,2,3), L=9:
  - pos 3 → all BLANK (31)
  - pos 7 → {31,31,1,2,3,31}
  - pos 8 then step → pos 0
- clr asserted with wr_en and step, N=5 → next cycle count=0, win_valid=0, window all 31, pos=0, no wr_drop.
- rst low mid-scroll asynchronously (between edges) → all outputs go to reset values before the next edge. After release, a write of 9 → {9,9,9,9,9,9} (no pad) or {9,31,31,31,31,31} (pad).

Source files
------------

// File: rtl/scroll_window_buffer.sv
// scroll_window_buffer
// Append-only character store that presents a registered WINDOW-wide view
// starting at a scroll position. The view either wraps (loop mode) or runs
// to an end position and halts (one-shot mode).
// Optional feature macro: SCROLL_BLANK_PAD_EN. When it is defined, WINDOW
// blank positions follow the message, so the text scrolls fully off the
// display before it repeats.
module scroll_window_buffer #(
    parameter int                CHAR_W = 5,
    parameter int                DEPTH  = 16,
    parameter int                WINDOW = 6,
    parameter logic [CHAR_W-1:0] BLANK  = 5'd31
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic [CHAR_W-1:0]          wr_data,
    input  logic                       step,
    input  logic                       restart,
    input  logic                       mode,
    output logic [WINDOW*CHAR_W-1:0]   win_data,
    output logic                       win_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       wr_full,
    output logic                       wr_drop,
    output logic                       done,
    output logic                       stopped
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int POS_W = $clog2(DEPTH + WINDOW + 1);
    // Virtual index pos+i can exceed the position range by up to WINDOW-1.
    localparam int VW    = POS_W + 1;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_SCROLL,
        ST_STOPPED
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          n_q, n_d;
    logic [POS_W-1:0]          pos_q, pos_d;
    logic                      done_d, drop_d;
    logic                      wr_accept;
    logic [POS_W-1:0]          len;
    logic [POS_W-1:0]          end_pos;
    logic [POS_W-1:0]          loop_next;
    logic [WINDOW*CHAR_W-1:0]  win_d;

    logic [CHAR_W-1:0]         mem [DEPTH];

    logic [WINDOW*CHAR_W-1:0]  win_q;
    logic                      valid_q;
    logic [CNT_W-1:0]          count_q;
    logic                      full_q;
    logic                      drop_q;
    logic                      done_q;
    logic                      stopped_q;

    // Sequence length seen by the scroller.
`ifdef SCROLL_BLANK_PAD_EN
    assign len = POS_W'(n_q) + POS_W'(WINDOW);
`else
    assign len = POS_W'(n_q);
`endif

    assign end_pos   = (len > POS_W'(WINDOW)) ? (len - POS_W'(WINDOW)) : '0;
    // pos stays below len while characters are stored, so pos+1 cannot overflow.
    assign loop_next = ((pos_q + POS_W'(1)) >= len) ? '0 : (pos_q + POS_W'(1));

    // Next-state logic: clear, then writes, then restart over step.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        pos_d     = pos_q;
        done_d    = 1'b0;
        drop_d    = 1'b0;
        wr_accept = 1'b0;
        if (clr) begin
            state_d = ST_EMPTY;
            n_d     = '0;
            pos_d   = '0;
        end else begin
            if (wr_en) begin
                if (n_q == CNT_W'(DEPTH)) begin
                    drop_d = 1'b1;
                end else begin
                    wr_accept = 1'b1;
                    n_d       = n_q + CNT_W'(1);
                end
            end
            if (restart) begin
                pos_d = '0;
                if (state_q == ST_STOPPED) begin
                    state_d = ST_SCROLL;
                end
            end else begin
                case (state_q)
                    ST_SCROLL: begin
                        if (step) begin
                            if (!mode) begin
                                pos_d = loop_next;
                            end else if (pos_q < end_pos) begin
                                pos_d = pos_q + POS_W'(1);
                            end else begin
                                done_d  = 1'b1;
                                state_d = ST_STOPPED;
                            end
                        end
                    end
                    ST_STOPPED: begin
                        // Falling back to loop mode releases the halt; a
                        // step arriving with it is a plain loop step.
                        if (!mode) begin
                            state_d = ST_SCROLL;
                            if (step) begin
                                pos_d = loop_next;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
            if (state_q == ST_EMPTY && wr_accept) begin
                state_d = ST_SCROLL;
            end
        end
    end

    // Per-character window selection from the current scroll state.
    for (genvar gi = 0; gi < WINDOW; gi++) begin : g_char
        logic [VW-1:0]     v;
        logic [CHAR_W-1:0] char_d;

        // Reduce the virtual index into the sequence and fetch or blank it.
        always_comb begin
            v = VW'(pos_q) + VW'(gi);
            if (!mode && len != '0) begin
                // v < len + WINDOW, so WINDOW subtractions always suffice.
                for (int k = 0; k < WINDOW; k++) begin
                    if (v >= VW'(len)) begin
                        v = v - VW'(len);
                    end
                end
            end
            char_d = BLANK;
            if (v < VW'(n_q)) begin
                char_d = mem[v[AW-1:0]];
            end
        end

        assign win_d[gi*CHAR_W +: CHAR_W] = char_d;
    end

    // Character storage; contents are never reset, reads are gated by N.
    always_ff @(posedge clk) begin
        if (rst && wr_accept) begin
            mem[n_q[AW-1:0]] <= wr_data;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_EMPTY;
            n_q       <= '0;
            pos_q     <= '0;
            win_q     <= {WINDOW{BLANK}};
            valid_q   <= 1'b0;
            count_q   <= '0;
            full_q    <= 1'b0;
            drop_q    <= 1'b0;
            done_q    <= 1'b0;
            stopped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            pos_q     <= pos_d;
            win_q     <= win_d;
            valid_q   <= (n_q != '0);
            count_q   <= n_q;
            full_q    <= (n_q == CNT_W'(DEPTH));
            drop_q    <= drop_d;
            done_q    <= done_d;
            stopped_q <= (state_d == ST_STOPPED);
        end
    end

    assign win_data  = win_q;
    assign win_valid = valid_q;
    assign count     = count_q;
    assign wr_full   = full_q;
    assign wr_drop   = drop_q;
    assign done      = done_q;
    assign stopped   = stopped_q;

endmodule

// File: tb/tb_scroll_window_buffer.sv
// Bench for scroll_window_buffer: a queue-based message model checked every
// cycle, plus literal window expectations from hand-worked scenarios.
module tb_scroll_window_buffer;

    localparam int CHAR_W = 5;
    localparam int DEPTH  = 16;
    localparam int WINDOW = 6;
    localparam int BLK    = 31;

    logic                       clk;
    logic                       rst;
    logic                       clr;
    logic                       wr_en;
    logic [CHAR_W-1:0]          wr_data;
    logic                       step;
    logic                       restart;
    logic                       mode;
    logic [WINDOW*CHAR_W-1:0]   win_data;
    logic                       win_valid;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic                       wr_full;
    logic                       wr_drop;
    logic                       done;
    logic                       stopped;

    int checks = 0;
    int errors = 0;

    scroll_window_buffer #(
        .CHAR_W (CHAR_W),
        .DEPTH  (DEPTH),
        .WINDOW (WINDOW),
        .BLANK  (5'd31)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .step      (step),
        .restart   (restart),
        .mode      (mode),
        .win_data  (win_data),
        .win_valid (win_valid),
        .count     (count),
        .wr_full   (wr_full),
        .wr_drop   (wr_drop),
        .done      (done),
        .stopped   (stopped)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [WINDOW*CHAR_W-1:0] pk(input int c0, input int c1, input int c2,
                                                    input int c3, input int c4, input int c5);
        return {5'(c5), 5'(c4), 5'(c3), 5'(c2), 5'(c1), 5'(c0)};
    endfunction

    // ---------------- behavioural model ----------------
    int m_msg[$];
    int m_pos;
    bit m_stp;

    function automatic int m_len();
`ifdef SCROLL_BLANK_PAD_EN
        return m_msg.size() + WINDOW;
`else
        return m_msg.size();
`endif
    endfunction

    function automatic logic [WINDOW*CHAR_W-1:0] m_window(input logic lp_mode);
        logic [WINDOW*CHAR_W-1:0] w;
        int n;
        int v;
        n = m_msg.size();
        w = '0;
        for (int i = 0; i < WINDOW; i++) begin
            v = m_pos + i;
            if (n != 0 && !lp_mode) v = v % m_len();
            w[i*CHAR_W +: CHAR_W] = (n != 0 && v < n) ? 5'(m_msg[v]) : 5'(BLK);
        end
        return w;
    endfunction

    logic [WINDOW*CHAR_W-1:0] e_win;
    logic                     e_valid, e_full, e_drop, e_done, e_stopped;
    int                       e_count;

    // Advance the model on every edge and compare all outputs just after it.
    initial begin
        int len_now;
        int end_now;
        forever begin
            @(posedge clk);
            if (!rst) begin
                m_msg.delete();
                m_pos     = 0;
                m_stp     = 1'b0;
                e_win     = pk(BLK, BLK, BLK, BLK, BLK, BLK);
                e_valid   = 1'b0;
                e_count   = 0;
                e_full    = 1'b0;
                e_drop    = 1'b0;
                e_done    = 1'b0;
                e_stopped = 1'b0;
            end else begin
                e_win   = m_window(mode);
                e_valid = (m_msg.size() != 0);
                e_count = m_msg.size();
                e_full  = (m_msg.size() == DEPTH);
                e_drop  = 1'b0;
                e_done  = 1'b0;
                if (clr) begin
                    m_msg.delete();
                    m_pos = 0;
                    m_stp = 1'b0;
                end else begin
                    len_now = m_len();
                    end_now = (len_now > WINDOW) ? len_now - WINDOW : 0;
                    if (restart) begin
                        m_pos = 0;
                        m_stp = 1'b0;
                    end else begin
                        if (m_stp && !mode) m_stp = 1'b0;
                        if (step && m_msg.size() != 0 && !m_stp) begin
                            if (!mode) begin
                                m_pos = (m_pos + 1 >= len_now) ? 0 : m_pos + 1;
                            end else if (m_pos < end_now) begin
                                m_pos = m_pos + 1;
                            end else begin
                                e_done = 1'b1;
                                m_stp  = 1'b1;
                            end
                        end
                    end
                    if (wr_en) begin
                        if (m_msg.size() == DEPTH) e_drop = 1'b1;
                        else m_msg.push_back(int'(wr_data));
                    end
                end
                e_stopped = m_stp;
            end
            #1;
            check("cyc_win",     64'(win_data),  64'(e_win));
            check("cyc_valid",   64'(win_valid), 64'(e_valid));
            check("cyc_count",   64'(count),     64'(e_count));
            check("cyc_full",    64'(wr_full),   64'(e_full));
            check("cyc_drop",    64'(wr_drop),   64'(e_drop));
            check("cyc_done",    64'(done),      64'(e_done));
            check("cyc_stopped", 64'(stopped),   64'(e_stopped));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input logic w, input int d, input logic s, input logic r, input logic c);
        @(negedge clk);
        wr_en   = w;
        wr_data = 5'(d);
        step    = s;
        restart = r;
        clr     = c;
        @(posedge clk);
        #2;
        $display("txn t=%0t wr=%0d data=%0d step=%0d restart=%0d clr=%0d mode=%0d count=%0d win=%h",
                 $time, w, d, s, r, c, mode, count, win_data);
    endtask

    task automatic idle();
        tick(1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_data = '0;
        step = 1'b0; restart = 1'b0; mode = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle();
        check("rst_win",   64'(win_data),  64'(pk(BLK, BLK, BLK, BLK, BLK, BLK)));
        check("rst_valid", 64'(win_valid), 64'd0);
        check("rst_count", 64'(count),     64'd0);

        // Loop mode with a three-character message.
        tick(1'b1, 1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 2, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 3, 1'b0, 1'b0, 1'b0);
        idle();
        check("loop_count", 64'(count), 64'd3);
        check("loop_valid", 64'(win_valid), 64'd1);
`ifdef SCROLL_BLANK_PAD_EN
        check("loop_pos0", 64'(win_data), 64'(pk(1, 2, 3, BLK, BLK, BLK)));
`else
        check("loop_pos0", 64'(win_data), 64'(pk(1, 2, 3, 1, 2, 3)));
`endif
        tick(1'b0, 0, 1'b1, 1'b0, 1'b0);
        idle();
`ifdef SCROLL_BLANK_PAD_EN
        check("loop_pos1", 64'(win_data), 64'(pk(2, 3, BLK, BLK, BLK, BLK)));
`else
        check("loop_pos1", 64'(win_data), 64'(pk(2, 3, 1, 2, 3, 1)));
`endif
        tick(1'b0, 0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 0, 1'b1, 1'b0, 1'b0);
        idle();
`ifdef SCROLL_BLANK_PAD_EN
        check("loop_pos3", 64'(win_data), 64'(pk(BLK, BLK, BLK, BLK, BLK, BLK)));
        repeat (4) tick(1'b0, 0, 1'b1, 1'b0, 1'b0);
        idle();
        check("pad_pos7", 64'(win_data), 64'(pk(BLK, BLK, 1, 2, 3, BLK)));
        tick(1'b0, 0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 0, 1'b1, 1'b0, 1'b0);
        idle();
        check("pad_wrap", 64'(win_data), 64'(pk(1, 2, 3, BLK, BLK, BLK)));
`else
        check("loop_wrap", 64'(win_data), 64'(pk(1, 2, 3, 1, 2, 3)));
`endif

        // Clear beats a simultaneous write and step.
        tick(1'b1, 4, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 5, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 6, 1'b1, 1'b0, 1'b1);
        check("clr_nodrop", 64'(wr_drop), 64'd0);
        idle();
        check("clr_count", 64'(count),     64'd0);
        check("clr_valid", 64'(win_valid), 64'd0);
        check("clr_win",   64'(win_data),  64'(pk(BLK, BLK, BLK, BLK, BLK, BLK)));

        // Fill to capacity, then one rejected write.
        for (int i = 0; i < DEPTH; i++) tick(1'b1, i, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 7, 1'b0, 1'b0, 1'b0);
        check("full_drop", 64'(wr_drop), 64'd1);
        idle();
        check("full_drop_end", 64'(wr_drop), 64'd0);
        check("full_flag",  64'(wr_full), 64'd1);
        check("full_count", 64'(count),   64'd16);
        check("full_win",   64'(win_data), 64'(pk(0, 1, 2, 3, 4, 5)));

        // One-shot over eight characters.
        tick(1'b0, 0, 1'b0, 1'b0, 1'b1);
        mode = 1'b1;
        for (int i = 0; i < 8; i++) tick(1'b1, i, 1'b0, 1'b0, 1'b0);
        idle();
        tick(1'b0, 0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 0, 1'b1, 1'b0, 1'b0);
        idle();
        check("os_pos2",     64'(win_data), 64'(pk(2, 3, 4, 5, 6, 7)));
        check("os_running",  64'(stopped),  64'd0);
        tick(1'b0, 0, 1'b1, 1'b0, 1'b0);
`ifndef SCROLL_BLANK_PAD_EN
        check("os_done",     64'(done),    64'd1);
        check("os_stopped",  64'(stopped), 64'd1);
`endif
        idle();
`ifndef SCROLL_BLANK_PAD_EN
        check("os_hold_win", 64'(win_data), 64'(pk(2, 3, 4, 5, 6, 7)));
`endif
        tick(1'b0, 0, 1'b1, 1'b0, 1'b0);
        check("os_no_redone", 64'(done), 64'd0);
        tick(1'b0, 0, 1'b0, 1'b1, 1'b0);
        check("os_restart_run", 64'(stopped), 64'd0);
        idle();
        check("os_restart_win", 64'(win_data), 64'(pk(0, 1, 2, 3, 4, 5)));

        // Halt again, then release by switching to loop mode.
        repeat (3) tick(1'b0, 0, 1'b1, 1'b0, 1'b0);
        mode = 1'b0;
        idle();
        check("mode_release", 64'(stopped), 64'd0);

        // Mixed write/step/restart/mode vectors; the model checks each cycle.
        for (int i = 0; i < 48; i++) begin
            mode = (i >= 20 && i < 40) ? 1'b1 : 1'b0;
            tick((i % 3) == 0, (i * 7) % 31, (i % 2) == 0, i == 30, 1'b0);
        end

        // Asynchronous reset between edges.
        tick(1'b0, 0, 1'b1, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        check("arst_win",     64'(win_data),  64'(pk(BLK, BLK, BLK, BLK, BLK, BLK)));
        check("arst_valid",   64'(win_valid), 64'd0);
        check("arst_count",   64'(count),     64'd0);
        check("arst_full",    64'(wr_full),   64'd0);
        check("arst_stopped", 64'(stopped),   64'd0);
        repeat (2) @(negedge clk);
        rst  = 1'b1;
        mode = 1'b0;
        tick(1'b1, 9, 1'b0, 1'b0, 1'b0);
        idle();
        check("arst_count1", 64'(count), 64'd1);
`ifdef SCROLL_BLANK_PAD_EN
        check("arst_win9", 64'(win_data), 64'(pk(9, BLK, BLK, BLK, BLK, BLK)));
`else
        check("arst_win9", 64'(win_data), 64'(pk(9, 9, 9, 9, 9, 9)));
`endif
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
